// File: rtl/ghash_pkg.sv
// Shared GHASH constants: block width, reduction constant, sequencer state encoding, clog2.
package ghash_pkg;

    localparam int NB_BLOCK_DEFAULT = 128;

    // x^128 + x^7 + x^2 + x + 1 in GCM (reflected) bit order
    localparam logic [127:0] R_POLY = {8'hE1, 120'h0};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } seq_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/gf_2to128_mult_reduce.sv
// Combinational GF(2^128) multiply with reduction, GCM bit order (bit 127 = x^0).
module gf_2to128_mult_reduce
    import ghash_pkg::*;
(
    input  logic [127:0] i_a,
    input  logic [127:0] i_b,
    output logic [127:0] o_p
);

    logic [127:0] z;
    logic [127:0] v;

    // Shift-and-add: walk i_a from x^0 upward, multiplying v by x each step
    always_comb begin
        z = '0;
        v = i_b;
        for (int i = 0; i < 128; i++) begin
            if (i_a[127-i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ R_POLY) : (v >> 1);
        end
    end

    assign o_p = z;

endmodule

// File: rtl/h_key_power_sequencer.sv
// Sequential H^1..H^N_BLOCKS generator on one shared GF(2^128) multiplier.
// Define H_POWER_PIPE_EN to register the product (two cycles per power step).
module h_key_power_sequencer
    import ghash_pkg::*;
#(
    parameter int NB_BLOCK = NB_BLOCK_DEFAULT,
    parameter int N_BLOCKS = 2,
    parameter int NB_DATA  = NB_BLOCK * N_BLOCKS
)
(
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic [NB_BLOCK-1:0] i_h_key,
    input  logic               i_h_key_valid,
    output logic               o_h_key_ready,
    output logic [NB_DATA-1:0] o_h_key_powers,
    output logic               o_powers_valid,
    output logic               o_busy
);

    localparam int CNT_W = clog2(N_BLOCKS) + 1;

    if (NB_BLOCK != 128) begin : g_bad_nb_block
        $error("h_key_power_sequencer: NB_BLOCK must be 128");
    end
    if (N_BLOCKS < 1) begin : g_bad_n_blocks
        $error("h_key_power_sequencer: N_BLOCKS must be >= 1");
    end

    seq_state_t                         state_q, state_d;
    logic [NB_BLOCK-1:0]                key_q;
    logic [N_BLOCKS-1:0][NB_BLOCK-1:0]  power_q;
    logic [CNT_W-1:0]                   cnt_q;
    logic [NB_BLOCK-1:0]                mult_a;
    logic [NB_BLOCK-1:0]                prod;
    logic [NB_BLOCK-1:0]                wr_data;
    logic                               wr_en;
    logic                               load;
    logic                               step_last;

    assign o_h_key_ready = 1'b1;
    assign load          = i_h_key_valid;

    // Operand is the previous power; cnt_q names the power being produced
    always_comb begin
        mult_a = '0;
        for (int i = 1; i < N_BLOCKS; i++)
            if (cnt_q == CNT_W'(i)) mult_a = power_q[i-1];
    end

    gf_2to128_mult_reduce u_mult (
        .i_a (mult_a),
        .i_b (key_q),
        .o_p (prod)
    );

`ifdef H_POWER_PIPE_EN
    logic                phase_q;
    logic [NB_BLOCK-1:0] prod_q;

    assign wr_en   = (state_q == CALC) && phase_q;
    assign wr_data = prod_q;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            phase_q <= 1'b0;
            prod_q  <= '0;
        end else if (load) begin
            phase_q <= 1'b0;
        end else if (state_q == CALC) begin
            phase_q <= ~phase_q;
            if (!phase_q) prod_q <= prod;
        end
    end
`else
    assign wr_en   = (state_q == CALC);
    assign wr_data = prod;
`endif

    assign step_last = wr_en && (cnt_q == CNT_W'(N_BLOCKS - 1));

    // A load in the same cycle as a step wins and drops the step write
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            key_q   <= '0;
            power_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            key_q      <= i_h_key;
            power_q    <= '0;
            power_q[0] <= i_h_key;
            cnt_q      <= CNT_W'(1);
        end else if (wr_en) begin
            for (int i = 1; i < N_BLOCKS; i++)
                if (cnt_q == CNT_W'(i)) power_q[i] <= wr_data;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CALC:    if (step_last) state_d = DONE;
            default: ;
        endcase
        if (load) state_d = (N_BLOCKS == 1) ? DONE : CALC;
    end

    assign o_h_key_powers = power_q;
    assign o_powers_valid = (state_q == DONE);
    assign o_busy         = (state_q == CALC);

endmodule

// File: tb/tb_h_key_power_sequencer.sv
// Directed bench for h_key_power_sequencer: N_BLOCKS = 4, 1 and 8 instances on one clock.
module tb_h_key_power_sequencer;

`ifdef H_POWER_PIPE_EN
    localparam int SPC = 2;
`else
    localparam int SPC = 1;
`endif
    localparam int LAT4 = 3 * SPC;
    localparam int LAT8 = 7 * SPC;

    localparam logic [127:0] H_ONE  = {1'b1, 127'h0};
    localparam logic [127:0] H_X1   = {2'b01, 126'h0};
    localparam logic [127:0] H_X64  = 128'h0000000000000000_8000000000000000;
    localparam logic [127:0] H_AES0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] H_SEQ  = 128'h0123456789abcdef0123456789abcdef;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key;
    logic         v4, v1, v8;
    logic         rdy4, rdy1, rdy8;
    logic [511:0] p4;
    logic [127:0] p1;
    logic [1023:0] p8;
    logic         pv4, pv1, pv8;
    logic         busy4, busy1, busy8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    h_key_power_sequencer #(.NB_BLOCK(128), .N_BLOCKS(4)) u4 (
        .i_clock(clk), .i_reset_n(rst_n), .i_h_key(key), .i_h_key_valid(v4),
        .o_h_key_ready(rdy4), .o_h_key_powers(p4), .o_powers_valid(pv4), .o_busy(busy4));
    h_key_power_sequencer #(.NB_BLOCK(128), .N_BLOCKS(1)) u1 (
        .i_clock(clk), .i_reset_n(rst_n), .i_h_key(key), .i_h_key_valid(v1),
        .o_h_key_ready(rdy1), .o_h_key_powers(p1), .o_powers_valid(pv1), .o_busy(busy1));
    h_key_power_sequencer #(.NB_BLOCK(128), .N_BLOCKS(8)) u8 (
        .i_clock(clk), .i_reset_n(rst_n), .i_h_key(key), .i_h_key_valid(v8),
        .o_h_key_ready(rdy8), .o_h_key_powers(p8), .o_powers_valid(pv8), .o_busy(busy8));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference multiply in plain polynomial form: full product, then fold high bits down
    function automatic logic [127:0] gmul_ref(input logic [127:0] a, input logic [127:0] b);
        logic [254:0] p;
        logic [254:0] rb;
        logic [127:0] r;
        p  = '0;
        rb = '0;
        for (int i = 0; i < 128; i++) rb[i] = b[127-i];
        for (int i = 0; i < 128; i++)
            if (a[127-i]) p = p ^ (rb << i);
        for (int j = 254; j >= 128; j--)
            if (p[j]) begin
                p[j]       = 1'b0;
                p[j-121]   = ~p[j-121];
                p[j-126]   = ~p[j-126];
                p[j-127]   = ~p[j-127];
                p[j-128]   = ~p[j-128];
            end
        for (int i = 0; i < 128; i++) r[127-i] = p[i];
        return r;
    endfunction

    task automatic load4(input logic [127:0] h);
        key = h; v4 = 1'b1;
        step();
        v4 = 1'b0;
    endtask

    task automatic chk4(input string tag, input logic [127:0] e0, input logic [127:0] e1,
                        input logic [127:0] e2, input logic [127:0] e3);
        chk({tag, "_s0"}, p4[0   +: 128], e0);
        chk({tag, "_s1"}, p4[128 +: 128], e1);
        chk({tag, "_s2"}, p4[256 +: 128], e2);
        chk({tag, "_s3"}, p4[384 +: 128], e3);
    endtask

    initial begin
        logic [127:0] exp_pw;
        int bc;
        int guard;

        rst_n = 1'b0; key = '0; v4 = 1'b0; v1 = 1'b0; v8 = 1'b0;
        step(); step();
        chk4("rst", '0, '0, '0, '0);
        chk("rst_vld",  pv4,   1'b0);
        chk("rst_busy", busy4, 1'b0);
        chk("rst_rdy",  rdy4,  1'b1);
        rst_n = 1'b1;
        step();

        // identity key: every power equals H
        load4(H_ONE);
        chk("id_p0",   p4[0 +: 128], H_ONE);
        chk("id_busy", busy4, 1'b1);
        for (int k = 1; k <= LAT4; k++) begin
            step();
            chk($sformatf("id_vld%0d", k), pv4, (k == LAT4));
        end
        chk4("id", H_ONE, H_ONE, H_ONE, H_ONE);
        chk("id_busy_end", busy4, 1'b0);

        // x^64: crosses the reduction boundary
        load4(H_X64);
        for (int k = 1; k <= LAT4; k++) step();
        chk4("x64", H_X64, {8'hE1, 120'h0}, {64'h0, 8'hE1, 56'h0}, {16'hA802, 112'h0});
        chk("x64_vld", pv4, 1'b1);

        // reset one cycle after accept
        load4(H_X64);
        rst_n = 1'b0;
        step();
        chk4("mrst", '0, '0, '0, '0);
        chk("mrst_vld",  pv4,   1'b0);
        chk("mrst_busy", busy4, 1'b0);
        rst_n = 1'b1;
        step(); step(); step();
        chk4("mrst_hold", '0, '0, '0, '0);
        chk("mrst_busy2", busy4, 1'b0);

        // restart two cycles into CALC
        load4(H_X64);
        step();
        load4(H_X1);
        chk4("rs0", H_X1, '0, '0, '0);
        for (int k = 1; k <= LAT4; k++) begin
            step();
            chk($sformatf("rs_vld%0d", k), pv4, (k == LAT4));
        end
        chk4("rs", H_X1, {3'b001, 125'h0}, {4'b0001, 124'h0}, {5'b00001, 123'h0});

        // load coincident with the final step
        load4(H_X64);
        for (int k = 1; k < LAT4; k++) step();
        load4(H_X1);
        chk("co_vld",  pv4,   1'b0);
        chk("co_busy", busy4, 1'b1);
        chk4("co0", H_X1, '0, '0, '0);
        for (int k = 1; k <= LAT4; k++) step();
        chk4("co", H_X1, {3'b001, 125'h0}, {4'b0001, 124'h0}, {5'b00001, 123'h0});
        chk("co_vld_end", pv4, 1'b1);

        // zero key
        load4('0);
        for (int k = 1; k <= LAT4; k++) step();
        chk4("zero", '0, '0, '0, '0);
        chk("zero_vld", pv4, 1'b1);

        // single power: valid straight after accept, never busy
        chk("n1_busy_pre", busy1, 1'b0);
        key = H_SEQ; v1 = 1'b1;
        step();
        v1 = 1'b0;
        chk("n1_p0",   p1,    H_SEQ);
        chk("n1_vld",  pv1,   1'b1);
        chk("n1_busy", busy1, 1'b0);
        chk("n1_rdy",  rdy1,  1'b1);
        step();
        chk("n1_busy2", busy1, 1'b0);

        // eight powers of the AES-derived H against the reference model
        key = H_AES0; v8 = 1'b1;
        step();
        v8 = 1'b0;
        bc = 0;
        guard = 0;
        while (!pv8 && guard < 50) begin
            if (busy8) bc++;
            step();
            guard++;
        end
        chk("n8_timeout", (guard < 50), 1'b1);
        chk("n8_busy_cycles", bc, LAT8);
        chk("n8_rdy", rdy8, 1'b1);
        exp_pw = H_AES0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("n8_s%0d", i), p8[i*128 +: 128], exp_pw);
            exp_pw = gmul_ref(exp_pw, H_AES0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
